// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

    // Action applied to the pipeline in a given cycle; values are visible on the state port
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Register $zero is never a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Advance by one on each event unless already at all-ones
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Synchronous reset clears the count
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: chooses run, load-use
// stall, branch flush or memory wait each cycle and drives the enables directly
// from the current inputs. Keeps event counters and a sticky memory-timeout flag.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mem_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic   wait_c;
    logic   flush_c;
    logic   lu_c;
    state_t action;

    state_t          state_q;
    logic [TW-1:0]   to_cnt_d;
    logic [TW-1:0]   to_cnt_q;
    logic            timeout_d;
    logic            timeout_q;

    // Hazard conditions and their priority: memory wait, then branch flush, then load-use
    always_comb begin
        wait_c  = mem_req & ~mem_ready;
        flush_c = mem_branch_taken;
        lu_c    = ex_mem_read & (ex_rt != REG_ZERO) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
        if (wait_c) begin
            action = WAIT;
        end else if (flush_c) begin
            action = FLUSH;
        end else if (lu_c) begin
            action = STALL;
        end else begin
            action = RUN;
        end
    end

    // Enables follow the chosen action immediately; reset forces every stage to a bubble
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (action)
                WAIT: begin
                    pipe_freeze = 1'b1;
                end
                FLUSH: begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end
                STALL: begin
                    idex_flush = 1'b1;
                end
                default: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            endcase
        end
    end

    // Consecutive-wait counter saturates at the limit; reaching it latches the error flag
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (action == WAIT) begin
            if (to_cnt_q != TW'(TIMEOUT)) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
        if (to_cnt_d == TW'(TIMEOUT)) begin
            timeout_d = 1'b1;
        end
    end

    // Record the applied action and the timeout tracking state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= action;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (action == STALL),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (action == FLUSH),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (action == WAIT),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a wide-counter instance for behaviour and a
// 2-bit-counter instance sharing the same stimulus for saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        mem_branch_taken;
    logic        mem_req;
    logic        mem_ready;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt, wait_cnt;
    logic        mem_timeout;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pipe_freeze;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_wait_cnt;
    logic        s_mem_timeout;

    int num_compared   = 0;
    int num_mismatched = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16), .TIMEOUT(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .pipe_freeze      (pipe_freeze),
        .state            (state),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt),
        .wait_cnt         (wait_cnt),
        .mem_timeout      (mem_timeout)
    );

    hazard_ctrl #(.CNT_W(2), .TIMEOUT(8)) dut_sat (
        .clk              (clk),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .pc_write         (s_pc_write),
        .ifid_write       (s_ifid_write),
        .ifid_flush       (s_ifid_flush),
        .idex_flush       (s_idex_flush),
        .exmem_flush      (s_exmem_flush),
        .pipe_freeze      (s_pipe_freeze),
        .state            (s_state),
        .stall_cnt        (s_stall_cnt),
        .flush_cnt        (s_flush_cnt),
        .wait_cnt         (s_wait_cnt),
        .mem_timeout      (s_mem_timeout)
    );

    // Drive one cycle of inputs away from the rising edge and let them settle
    task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic mem_rd, input logic [4:0] exrt,
                                 input logic br, input logic req, input logic rdy);
        @(negedge clk);
        reset            = rst;
        id_rs            = rs;
        id_rt            = rt;
        id_uses_rt       = uses_rt;
        ex_mem_read      = mem_rd;
        ex_rt            = exrt;
        mem_branch_taken = br;
        mem_req          = req;
        mem_ready        = rdy;
        #2;
    endtask

    // Let the current inputs be applied at the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        assert (observed === expected) else begin
            num_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Checks all six enables against {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze}
    task automatic checkEnables(input string tag, input logic [5:0] expected);
        checkOutput(tag, {26'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze},
                    {26'd0, expected});
    endtask

    initial begin
        reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rt = '0; mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        // Reset: bubble everywhere, then everything cleared
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkEnables("reset_enables", 6'b001110);
        tick();
        checkOutput("reset_state", state, 0);
        checkOutput("reset_stall_cnt", stall_cnt, 0);
        checkOutput("reset_flush_cnt", flush_cnt, 0);
        checkOutput("reset_wait_cnt", wait_cnt, 0);
        checkOutput("reset_timeout", mem_timeout, 0);

        // Plain run
        applyStimulus(0, 1, 2, 1, 0, 0, 0, 0, 0);
        checkEnables("run_enables", 6'b110000);
        tick();
        checkOutput("run_state", state, 0);

        // Load-use on rs
        applyStimulus(0, 5, 2, 0, 1, 5, 0, 0, 0);
        checkEnables("lu_rs_enables", 6'b000100);
        tick();
        checkOutput("lu_rs_state", state, 1);
        checkOutput("lu_rs_stall_cnt", stall_cnt, 1);

        // Bubble now in ID/EX: back to run
        applyStimulus(0, 5, 2, 0, 0, 0, 0, 0, 0);
        checkEnables("post_bubble_enables", 6'b110000);
        tick();
        checkOutput("post_bubble_state", state, 0);

        // Load into $zero never stalls
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        checkEnables("zero_reg_enables", 6'b110000);
        tick();

        // rt match ignored when rt is not a source
        applyStimulus(0, 3, 7, 0, 1, 7, 0, 0, 0);
        checkEnables("rt_unused_enables", 6'b110000);
        tick();
        checkOutput("rt_unused_stall_cnt", stall_cnt, 1);

        // rt match when rt is a source stalls
        applyStimulus(0, 3, 7, 1, 1, 7, 0, 0, 0);
        checkEnables("lu_rt_enables", 6'b000100);
        tick();
        checkOutput("lu_rt_stall_cnt", stall_cnt, 2);

        // Branch together with load-use: flush wins
        applyStimulus(0, 5, 2, 0, 1, 5, 1, 0, 0);
        checkEnables("br_lu_enables", 6'b111110);
        tick();
        checkOutput("br_lu_state", state, 2);
        checkOutput("br_lu_flush_cnt", flush_cnt, 1);
        checkOutput("br_lu_stall_cnt", stall_cnt, 2);

        // Memory wait for 4 cycles with a pending branch, then flush when ready
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 2, 0, 0, 0, 1, 1, 0);
            checkEnables("wait_enables", 6'b000001);
            tick();
            checkOutput("wait_state", state, 3);
        end
        applyStimulus(0, 1, 2, 0, 0, 0, 1, 1, 1);
        checkEnables("wait_release_flush", 6'b111110);
        tick();
        checkOutput("wait_release_state", state, 2);
        checkOutput("wait_wait_cnt", wait_cnt, 4);
        checkOutput("wait_flush_cnt", flush_cnt, 2);
        checkOutput("wait_sat_wait_cnt", s_wait_cnt, 3);
        checkOutput("wait_short_no_timeout", mem_timeout, 0);

        // Timeout after 8 consecutive waits
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1, 2, 0, 0, 0, 0, 1, 0);
            tick();
            checkOutput("timeout_progress", mem_timeout, (i == 8) ? 1 : 0);
        end
        applyStimulus(0, 1, 2, 0, 0, 0, 0, 1, 1);
        checkEnables("timeout_ready_run", 6'b110000);
        tick();
        checkOutput("timeout_sticky", mem_timeout, 1);
        checkOutput("timeout_wait_cnt", wait_cnt, 12);

        // Five more stalls: wide counter reaches 7, 2-bit counter sticks at 3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 9, 2, 0, 1, 9, 0, 0, 0);
            tick();
        end
        checkOutput("sat_stall_wide", stall_cnt, 7);
        checkOutput("sat_stall_narrow", s_stall_cnt, 3);

        // Enter a wait, then assert reset mid-wait
        applyStimulus(0, 1, 2, 0, 0, 0, 0, 1, 0);
        tick();
        checkOutput("pre_reset_state", state, 3);
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 1, 0);
        checkEnables("reset_mid_wait_enables", 6'b001110);
        tick();
        checkOutput("post_reset_state", state, 0);
        checkOutput("post_reset_stall_cnt", stall_cnt, 0);
        checkOutput("post_reset_flush_cnt", flush_cnt, 0);
        checkOutput("post_reset_wait_cnt", wait_cnt, 0);
        checkOutput("post_reset_timeout", mem_timeout, 0);
        checkOutput("post_reset_narrow_stall", s_stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
